// File: rtl/icache_if.sv
// icache_if: fetcher and refill-controller signals of the instruction cache
interface icache_if;
  logic         fetch_req;
  logic [31:0]  fetch_pc;
  logic         fetch_hit;
  logic [31:0]  fetch_ins;
  logic         flush;
  logic [31:0]  mem_pc;
  logic         mem_miss;
  logic         mem_finish;
  logic [511:0] mem_line;
  modport slave (
    input  fetch_req, fetch_pc, flush, mem_finish, mem_line,
    output fetch_hit, fetch_ins, mem_pc, mem_miss
  );
  modport master (
    output fetch_req, fetch_pc, flush, mem_finish, mem_line,
    input  fetch_hit, fetch_ins, mem_pc, mem_miss
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped 16x64B instruction cache with edge-triggered refill completion
module icache (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  icache_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t         r_state, w_next;
  logic           r_fin_q;
  logic [15:0]    r_valid;
  logic [21:0]    r_tag [16];
  logic [511:0]   r_data [16];
  logic           r_hit, r_miss;
  logic [31:0]    r_ins;
  logic [31:6]    r_pc;
  logic [31:2]    r_lpc;
  logic           w_fin_edge, w_lookup, w_wr, w_clr;
  logic [3:0]     w_idx;
  logic [31:0]    w_hit_word, w_fill_word;
  logic           w_hit_n, w_miss_n;
  logic [31:0]    w_ins_n;
  logic [31:6]    w_pc_n;
  logic [31:2]    w_lpc_n;
  assign w_fin_edge  = bus.mem_finish & ~r_fin_q;
  assign w_idx       = bus.fetch_pc[9:6];
  assign w_lookup    = r_valid[w_idx] && (r_tag[w_idx] == bus.fetch_pc[31:10]);
  assign w_hit_word  = r_data[w_idx][{bus.fetch_pc[5:2], 5'b0} +: 32];
  assign w_fill_word = bus.mem_line[{r_lpc[5:2], 5'b0} +: 32];
  assign bus.fetch_hit = r_hit;
  assign bus.fetch_ins = r_ins;
  assign bus.mem_miss  = r_miss;
  assign bus.mem_pc    = {r_pc, 6'b0};
  always_comb begin
    w_next   = r_state;
    w_hit_n  = 1'b0;
    w_ins_n  = r_ins;
    w_miss_n = r_miss;
    w_pc_n   = r_pc;
    w_lpc_n  = r_lpc;
    w_wr     = 1'b0;
    w_clr    = bus.flush;
    case (r_state)
      IDLE: begin
        if (!bus.flush && bus.fetch_req && w_lookup) begin
          w_hit_n = 1'b1;
          w_ins_n = w_hit_word;
        end else if (!bus.flush && bus.fetch_req) begin
          w_lpc_n  = bus.fetch_pc[31:2];
          w_pc_n   = bus.fetch_pc[31:6];
          w_miss_n = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        if (bus.flush) begin
          w_miss_n = 1'b0;
          w_next   = w_fin_edge ? IDLE : DRAIN;
        end else if (w_fin_edge) begin
          w_wr     = 1'b1;
          w_miss_n = 1'b0;
          w_hit_n  = 1'b1;
          w_ins_n  = w_fill_word;
          w_next   = IDLE;
        end
      end
      default: w_next = w_fin_edge ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_fin_q <= 1'b0;
      r_valid <= '0;
      r_hit   <= 1'b0;
      r_ins   <= '0;
      r_miss  <= 1'b0;
      r_pc    <= '0;
      r_lpc   <= '0;
    end else if (rdy) begin
      r_state <= w_next;
      r_fin_q <= bus.mem_finish;
      r_valid <= w_clr ? '0 : w_wr ? (r_valid | (16'd1 << r_lpc[9:6])) : r_valid;
      r_hit   <= w_hit_n;
      r_ins   <= w_ins_n;
      r_miss  <= w_miss_n;
      r_pc    <= w_pc_n;
      r_lpc   <= w_lpc_n;
    end
  end
  // arrays carry no reset; validity alone decides whether their contents are used
  always_ff @(posedge clk) begin
    if (rdy && w_wr) begin
      r_tag[r_lpc[9:6]]  <= r_lpc[31:10];
      r_data[r_lpc[9:6]] <= bus.mem_line;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for the instruction cache
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;
  icache_if bus ();
  icache dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [511:0] mk_line(input logic [31:0] s);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = s + 32'(w);
    return l;
  endfunction
  task automatic test_reset;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got %h exp %h", bus.fetch_hit, 1'b0); end
    checks++; if (bus.fetch_ins !== 32'h0) begin errors++; $display("FAIL rst_ins got %h exp %h", bus.fetch_ins, 32'h0); end
    checks++; if (bus.mem_miss !== 1'b0) begin errors++; $display("FAIL rst_miss got %h exp %h", bus.mem_miss, 1'b0); end
    checks++; if (bus.mem_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.mem_pc, 32'h0); end
  endtask
  task automatic test_cold_miss;
    logic [511:0] l;
    l = mk_line(32'h1000_0000);
    l[63:32] = 32'h00A0_0093;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1044;
    tick;
    checks++; if (bus.mem_miss !== 1'b1) begin errors++; $display("FAIL cold_miss got %h exp %h", bus.mem_miss, 1'b1); end
    checks++; if (bus.mem_pc !== 32'h0000_1040) begin errors++; $display("FAIL cold_pc got %h exp %h", bus.mem_pc, 32'h0000_1040); end
    bus.fetch_pc = 32'h2222_0000;
    for (int i = 0; i < 69; i++) begin
      tick;
      checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b1 || bus.mem_pc !== 32'h0000_1040) begin errors++; $display("FAIL cold_wait got hit %h miss %h pc %h exp 0 1 00001040", bus.fetch_hit, bus.mem_miss, bus.mem_pc); end
    end
    bus.mem_line = l; bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1) begin errors++; $display("FAIL cold_hit got %h exp %h", bus.fetch_hit, 1'b1); end
    checks++; if (bus.fetch_ins !== 32'h00A0_0093) begin errors++; $display("FAIL cold_ins got %h exp %h", bus.fetch_ins, 32'h00A0_0093); end
    checks++; if (bus.mem_miss !== 1'b0) begin errors++; $display("FAIL cold_miss_drop got %h exp %h", bus.mem_miss, 1'b0); end
    bus.fetch_req = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL cold_pulse got %h exp %h", bus.fetch_hit, 1'b0); end
  endtask
  task automatic test_hit;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1048;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1) begin errors++; $display("FAIL hit_hit got %h exp %h", bus.fetch_hit, 1'b1); end
    checks++; if (bus.fetch_ins !== 32'h1000_0002) begin errors++; $display("FAIL hit_ins got %h exp %h", bus.fetch_ins, 32'h1000_0002); end
    checks++; if (bus.mem_miss !== 1'b0) begin errors++; $display("FAIL hit_miss got %h exp %h", bus.mem_miss, 1'b0); end
    bus.fetch_req = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL hit_pulse got %h exp %h", bus.fetch_hit, 1'b0); end
    checks++; if (bus.fetch_ins !== 32'h1000_0002) begin errors++; $display("FAIL hit_ins_hold got %h exp %h", bus.fetch_ins, 32'h1000_0002); end
  endtask
  task automatic test_conflict;
    logic [511:0] l;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1444;
    tick;
    checks++; if (bus.mem_miss !== 1'b1) begin errors++; $display("FAIL conf_miss got %h exp %h", bus.mem_miss, 1'b1); end
    checks++; if (bus.mem_pc !== 32'h0000_1440) begin errors++; $display("FAIL conf_pc got %h exp %h", bus.mem_pc, 32'h0000_1440); end
    bus.mem_finish = 1'b0;
    tick;
    tick;
    bus.mem_line = mk_line(32'h2000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h2000_0001) begin errors++; $display("FAIL conf_fill got hit %h ins %h exp 1 20000001", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_pc = 32'h0000_1044;
    tick;
    checks++; if (bus.mem_miss !== 1'b1 || bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL conf_evict got miss %h hit %h exp 1 0", bus.mem_miss, bus.fetch_hit); end
    checks++; if (bus.mem_pc !== 32'h0000_1040) begin errors++; $display("FAIL conf_evict_pc got %h exp %h", bus.mem_pc, 32'h0000_1040); end
    bus.mem_finish = 1'b0;
    tick;
    l = mk_line(32'h1000_0000);
    l[63:32] = 32'h00A0_0093;
    bus.mem_line = l; bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h00A0_0093) begin errors++; $display("FAIL conf_refill got hit %h ins %h exp 1 00a00093", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  task automatic test_sticky;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_2000;
    tick;
    checks++; if (bus.mem_miss !== 1'b1 || bus.mem_pc !== 32'h0000_2000) begin errors++; $display("FAIL sticky_miss got miss %h pc %h exp 1 00002000", bus.mem_miss, bus.mem_pc); end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b1) begin errors++; $display("FAIL sticky_level got hit %h miss %h exp 0 1", bus.fetch_hit, bus.mem_miss); end
    end
    bus.mem_finish = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL sticky_low got %h exp %h", bus.fetch_hit, 1'b0); end
    bus.mem_line = mk_line(32'h3000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h3000_0000) begin errors++; $display("FAIL sticky_fill got hit %h ins %h exp 1 30000000", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  task automatic test_flush_idle;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_2000; bus.flush = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b0) begin errors++; $display("FAIL flidle_resp got hit %h miss %h exp 0 0", bus.fetch_hit, bus.mem_miss); end
    bus.flush = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b1) begin errors++; $display("FAIL flidle_inval got hit %h miss %h exp 0 1", bus.fetch_hit, bus.mem_miss); end
    bus.mem_finish = 1'b0;
    tick;
    bus.mem_line = mk_line(32'h5000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h5000_0000) begin errors++; $display("FAIL flidle_fill got hit %h ins %h exp 1 50000000", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  task automatic test_flush_req;
    bus.mem_finish = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_3004;
    tick;
    checks++; if (bus.mem_miss !== 1'b1 || bus.mem_pc !== 32'h0000_3000) begin errors++; $display("FAIL flreq_miss got miss %h pc %h exp 1 00003000", bus.mem_miss, bus.mem_pc); end
    bus.flush = 1'b1; bus.fetch_req = 1'b0;
    tick;
    checks++; if (bus.mem_miss !== 1'b0 || bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL flreq_drop got miss %h hit %h exp 0 0", bus.mem_miss, bus.fetch_hit); end
    bus.flush = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1044;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (bus.mem_miss !== 1'b0 || bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL flreq_drain got miss %h hit %h exp 0 0", bus.mem_miss, bus.fetch_hit); end
    end
    bus.fetch_req = 1'b0;
    bus.mem_line = mk_line(32'h6000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.mem_miss !== 1'b0 || bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL flreq_fin got miss %h hit %h exp 0 0", bus.mem_miss, bus.fetch_hit); end
    bus.mem_finish = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_3004;
    tick;
    checks++; if (bus.mem_miss !== 1'b1 || bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL flreq_refetch got miss %h hit %h exp 1 0", bus.mem_miss, bus.fetch_hit); end
    bus.mem_line = mk_line(32'h4000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h4000_0001) begin errors++; $display("FAIL flreq_fill got hit %h ins %h exp 1 40000001", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  task automatic test_flush_fin_same;
    bus.mem_finish = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_7000;
    tick;
    bus.flush = 1'b1; bus.mem_line = mk_line(32'h7000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b0) begin errors++; $display("FAIL flfin_resp got hit %h miss %h exp 0 0", bus.fetch_hit, bus.mem_miss); end
    bus.flush = 1'b0;
    tick;
    checks++; if (bus.mem_miss !== 1'b1) begin errors++; $display("FAIL flfin_idle_miss got %h exp %h", bus.mem_miss, 1'b1); end
    bus.mem_finish = 1'b0;
    tick;
    bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h7000_0000) begin errors++; $display("FAIL flfin_fill got hit %h ins %h exp 1 70000000", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  task automatic test_rdy;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_7000; rdy = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL rdy_freeze got %h exp %h", bus.fetch_hit, 1'b0); end
    rdy = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h7000_0000) begin errors++; $display("FAIL rdy_resume got hit %h ins %h exp 1 70000000", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0; rdy = 1'b0;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1) begin errors++; $display("FAIL rdy_hold got %h exp %h", bus.fetch_hit, 1'b1); end
    rdy = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL rdy_release got %h exp %h", bus.fetch_hit, 1'b0); end
  endtask
  task automatic test_async_reset;
    bus.mem_finish = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_5000;
    tick;
    checks++; if (bus.mem_miss !== 1'b1) begin errors++; $display("FAIL arst_pre got %h exp %h", bus.mem_miss, 1'b1); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_miss !== 1'b0 || bus.mem_pc !== 32'h0) begin errors++; $display("FAIL arst_now got miss %h pc %h exp 0 00000000", bus.mem_miss, bus.mem_pc); end
    bus.fetch_req = 1'b0; bus.mem_finish = 1'b1;
    tick;
    rst = 1'b1; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_3004;
    tick;
    checks++; if (bus.mem_miss !== 1'b1 || bus.mem_pc !== 32'h0000_3000) begin errors++; $display("FAIL arst_refetch got miss %h pc %h exp 1 00003000", bus.mem_miss, bus.mem_pc); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (bus.fetch_hit !== 1'b0 || bus.mem_miss !== 1'b1) begin errors++; $display("FAIL arst_level got hit %h miss %h exp 0 1", bus.fetch_hit, bus.mem_miss); end
    end
    bus.mem_finish = 1'b0;
    tick;
    bus.mem_line = mk_line(32'h4000_0000); bus.mem_finish = 1'b1;
    tick;
    checks++; if (bus.fetch_hit !== 1'b1 || bus.fetch_ins !== 32'h4000_0001) begin errors++; $display("FAIL arst_fill got hit %h ins %h exp 1 40000001", bus.fetch_hit, bus.fetch_ins); end
    bus.fetch_req = 1'b0;
    tick;
  endtask
  initial begin
    rst = 1'b0; rdy = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.flush = 1'b0;
    bus.mem_finish = 1'b0; bus.mem_line = '0;
    tick;
    tick;
    test_reset;
    rst = 1'b1;
    tick;
    test_cold_miss;
    test_hit;
    test_conflict;
    test_sticky;
    test_flush_idle;
    test_flush_req;
    test_flush_fin_same;
    test_rdy;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
